// File: rtl/sw_debouncer_pkg.sv
// sw_debouncer_pkg
//   Shared types and default sizing for the switch debouncer slice.
//   - deb_state_e : per-channel debounce FSM state (IDLE, WAIT)
//   - *_DEF       : default parameter values used by sw_debouncer and
//                   debounce_channel
package sw_debouncer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } deb_state_e;

    localparam int NB_SW_DEF           = 4;
    localparam int NB_COUNTER_DEF      = 14;
    localparam int DEBOUNCE_CYCLES_DEF = 10000;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One switch bit: two-flop synchroniser, debounce counter with a two-state
//   FSM, the committed stable level and registered rise/fall pulses.
//   Ports:
//     clock     in   system clock, rising edge
//     i_reset_n in   asynchronous active-low reset
//     i_sw      in   raw switch bit, asynchronous to clock
//     o_stable  out  debounced level
//     o_rise    out  one-cycle pulse on a committed 0->1 change
//     o_fall    out  one-cycle pulse on a committed 1->0 change
module debounce_channel
    import sw_debouncer_pkg::*;
#(
    parameter int NB_COUNTER      = NB_COUNTER_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic i_reset_n,
    input  logic i_sw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    generate
        if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** NB_COUNTER) - 1) begin : g_bad_cfg
            $error("debounce_channel: DEBOUNCE_CYCLES out of range for NB_COUNTER");
        end
    endgenerate

    localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);

    logic                  sync_meta;
    logic                  sync;
    deb_state_e            state;
    deb_state_e            state_next;
    logic [NB_COUNTER-1:0] cnt;
    logic [NB_COUNTER-1:0] cnt_next;
    logic                  stable_next;
    logic                  rise_next;
    logic                  fall_next;

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            o_stable  <= 1'b0;
            o_rise    <= 1'b0;
            o_fall    <= 1'b0;
        end else begin
            sync_meta <= i_sw;
            sync      <= sync_meta;
            state     <= state_next;
            cnt       <= cnt_next;
            o_stable  <= stable_next;
            o_rise    <= rise_next;
            o_fall    <= fall_next;
        end
    end

    // The commit compare bounds cnt, so it can never wrap.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        stable_next = o_stable;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        case (state)
            IDLE: begin
                if (sync != o_stable) begin
                    state_next = WAIT;
                    cnt_next   = NB_COUNTER'(1);
                end else begin
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                if (sync == o_stable) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    stable_next = sync;
                    rise_next   = sync;
                    fall_next   = ~sync;
                    state_next  = IDLE;
                    cnt_next    = '0;
                end else begin
                    cnt_next    = cnt + NB_COUNTER'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/sw_debouncer.sv
// sw_debouncer
//   Board switch conditioner: NB_SW independent debounce channels plus a
//   sticky event mask with valid/ack handshake.
//   Optional feature macro: SW_DEBOUNCER_TOGGLE_EN (toggle-mode levels on
//   o_sw_toggle; tied to 0 when undefined).
//   Ports:
//     clock         in   system clock, rising edge
//     i_reset_n     in   asynchronous active-low reset
//     i_sw          in   raw switch inputs
//     o_sw_stable   out  debounced levels
//     o_sw_rise     out  one-cycle committed 0->1 pulses
//     o_sw_fall     out  one-cycle committed 1->0 pulses
//     o_event_valid out  high while o_event_mask is non-zero
//     o_event_mask  out  sticky set of channels changed since last ack
//     i_event_ack   in   clears the mask bits currently presented
//     o_sw_toggle   out  per-channel level flipped on each rise
module sw_debouncer
    import sw_debouncer_pkg::*;
#(
    parameter int NB_SW           = NB_SW_DEF,
    parameter int NB_COUNTER      = NB_COUNTER_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clock,
    input  logic             i_reset_n,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw_stable,
    output logic [NB_SW-1:0] o_sw_rise,
    output logic [NB_SW-1:0] o_sw_fall,
    output logic             o_event_valid,
    output logic [NB_SW-1:0] o_event_mask,
    input  logic             i_event_ack,
    output logic [NB_SW-1:0] o_sw_toggle
);

    logic [NB_SW-1:0] mask_next;

    generate
        for (genvar i = 0; i < NB_SW; i++) begin : g_ch
            debounce_channel #(
                .NB_COUNTER      (NB_COUNTER),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_ch (
                .clock     (clock),
                .i_reset_n (i_reset_n),
                .i_sw      (i_sw[i]),
                .o_stable  (o_sw_stable[i]),
                .o_rise    (o_sw_rise[i]),
                .o_fall    (o_sw_fall[i])
            );
        end
    endgenerate

    // Ack clears only the bits presented this cycle; a pulse arriving in the
    // same cycle survives the ack.
    always_comb begin
        mask_next = (o_event_mask & ~(i_event_ack ? o_event_mask : '0))
                  | o_sw_rise | o_sw_fall;
    end

    // Valid is registered from mask_next so it has no combinational path
    // from i_event_ack.
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_event_mask  <= '0;
            o_event_valid <= 1'b0;
        end else begin
            o_event_mask  <= mask_next;
            o_event_valid <= |mask_next;
        end
    end

`ifdef SW_DEBOUNCER_TOGGLE_EN
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_sw_toggle <= '0;
        end else begin
            o_sw_toggle <= o_sw_toggle ^ o_sw_rise;
        end
    end
`else
    assign o_sw_toggle = '0;
`endif

endmodule

// File: tb/tb_sw_debouncer.sv
module tb_sw_debouncer;

    localparam int NSW = 4;
    localparam int DEB = 8;
    localparam int LAT = DEB + 2;

    logic           clock;
    logic           i_reset_n;
    logic [NSW-1:0] i_sw;
    logic [NSW-1:0] o_sw_stable;
    logic [NSW-1:0] o_sw_rise;
    logic [NSW-1:0] o_sw_fall;
    logic           o_event_valid;
    logic [NSW-1:0] o_event_mask;
    logic           i_event_ack;
    logic [NSW-1:0] o_sw_toggle;

    typedef struct {
        int             due;
        logic [NSW-1:0] rise;
        logic [NSW-1:0] fall;
        logic [NSW-1:0] stable;
    } exp_t;

    exp_t           q[$];
    int             total = 0;
    int             bad   = 0;
    int             cyc   = 0;
    logic [NSW-1:0] model_stable = '0;
    logic [NSW-1:0] tog_model    = '0;

    sw_debouncer #(
        .NB_SW           (NSW),
        .NB_COUNTER      (4),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock         (clock),
        .i_reset_n     (i_reset_n),
        .i_sw          (i_sw),
        .o_sw_stable   (o_sw_stable),
        .o_sw_rise     (o_sw_rise),
        .o_sw_fall     (o_sw_fall),
        .o_event_valid (o_event_valid),
        .o_event_mask  (o_event_mask),
        .i_event_ack   (i_event_ack),
        .o_sw_toggle   (o_sw_toggle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard consumer: every pulse must match the oldest expectation in
    // timing, direction and resulting stable level.
    always @(negedge clock) begin
        if (i_reset_n) begin
            if ((o_sw_rise | o_sw_fall) != '0) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse cyc=%0d rise=%b fall=%b", cyc, o_sw_rise, o_sw_fall);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (cyc !== e.due || o_sw_rise !== e.rise || o_sw_fall !== e.fall
                        || o_sw_stable !== e.stable) begin
                        bad++;
                        $display("FAIL pulse cyc=%0d/%0d rise=%b/%b fall=%b/%b stable=%b/%b (got/exp)",
                                 cyc, e.due, o_sw_rise, e.rise, o_sw_fall, e.fall, o_sw_stable, e.stable);
                    end
                    tog_model = tog_model ^ e.rise;
                end
            end else if (q.size() != 0 && cyc > q[0].due) begin
                exp_t e;
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL missed_pulse due=%0d now=%0d rise=%b fall=%b", e.due, cyc, e.rise, e.fall);
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic drive_sw(input logic [NSW-1:0] v, output int due);
        logic [NSW-1:0] ch;
        exp_t e;
        ch = v ^ model_stable;
        i_sw = v;
        due = cyc + LAT;
        if (ch != '0) begin
            e.due    = due;
            e.rise   = v & ch;
            e.fall   = ~v & ch;
            e.stable = v;
            q.push_back(e);
            model_stable = v;
        end
    endtask

    task automatic ack_pulse();
        @(negedge clock);
        i_event_ack = 1'b1;
        @(negedge clock);
        i_event_ack = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_sw = '0;
        i_event_ack = 1'b0;
        repeat (3) @(negedge clock);
        total += 6;
        if (o_sw_stable !== '0) begin bad++; $display("FAIL rst_stable got=%b exp=0000", o_sw_stable); end
        if (o_sw_rise !== '0) begin bad++; $display("FAIL rst_rise got=%b exp=0000", o_sw_rise); end
        if (o_sw_fall !== '0) begin bad++; $display("FAIL rst_fall got=%b exp=0000", o_sw_fall); end
        if (o_event_mask !== '0) begin bad++; $display("FAIL rst_mask got=%b exp=0000", o_event_mask); end
        if (o_event_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", o_event_valid); end
        if (o_sw_toggle !== '0) begin bad++; $display("FAIL rst_toggle got=%b exp=0000", o_sw_toggle); end
        i_reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single_rise();
        int due;
        drive_sw(4'b0001, due);
        wait_cyc(due - 1);
        total++;
        if (o_sw_stable !== 4'b0000) begin bad++; $display("FAIL early_stable got=%b exp=0000", o_sw_stable); end
        wait_cyc(due + 1);
        total += 4;
        if (o_sw_stable !== 4'b0001) begin bad++; $display("FAIL rise_stable got=%b exp=0001", o_sw_stable); end
        if (o_sw_rise !== 4'b0000) begin bad++; $display("FAIL rise_width got=%b exp=0000", o_sw_rise); end
        if (o_event_mask !== 4'b0001) begin bad++; $display("FAIL rise_mask got=%b exp=0001", o_event_mask); end
        if (o_event_valid !== 1'b1) begin bad++; $display("FAIL rise_valid got=%b exp=1", o_event_valid); end
    endtask

    task automatic test_ack();
        @(negedge clock);
        i_event_ack = 1'b1;
        @(negedge clock);
        i_event_ack = 1'b0;
        total += 2;
        if (o_event_mask !== 4'b0000) begin bad++; $display("FAIL ack_mask got=%b exp=0000", o_event_mask); end
        if (o_event_valid !== 1'b0) begin bad++; $display("FAIL ack_valid got=%b exp=0", o_event_valid); end
        // Ack against an empty mask must leave it empty.
        ack_pulse();
        total++;
        if (o_event_mask !== 4'b0000) begin bad++; $display("FAIL ack_empty got=%b exp=0000", o_event_mask); end
    endtask

    task automatic test_bounce();
        int due;
        for (int k = 0; k < 20; k++) begin
            i_sw[1] = ~i_sw[1];
            repeat (3) @(negedge clock);
        end
        total++;
        if (o_sw_stable !== 4'b0001) begin bad++; $display("FAIL bounce_hold got=%b exp=0001", o_sw_stable); end
        drive_sw(4'b0011, due);
        wait_cyc(due + 1);
        total += 2;
        if (o_sw_stable !== 4'b0011) begin bad++; $display("FAIL bounce_stable got=%b exp=0011", o_sw_stable); end
        if (o_event_mask !== 4'b0010) begin bad++; $display("FAIL bounce_mask got=%b exp=0010", o_event_mask); end
    endtask

    task automatic test_ack_collision();
        int due;
        ack_pulse();
        drive_sw(4'b0111, due);
        wait_cyc(due + 1);
        ack_pulse();
        drive_sw(4'b0110, due);
        wait_cyc(due + 1);
        total++;
        if (o_event_mask !== 4'b0001) begin bad++; $display("FAIL coll_pre_mask got=%b exp=0001", o_event_mask); end
        drive_sw(4'b0010, due);
        wait_cyc(due);
        i_event_ack = 1'b1;
        @(negedge clock);
        i_event_ack = 1'b0;
        total += 3;
        if (o_event_mask !== 4'b0100) begin bad++; $display("FAIL coll_mask got=%b exp=0100", o_event_mask); end
        if (o_event_valid !== 1'b1) begin bad++; $display("FAIL coll_valid got=%b exp=1", o_event_valid); end
        if (o_sw_stable !== 4'b0010) begin bad++; $display("FAIL coll_stable got=%b exp=0010", o_sw_stable); end
    endtask

    task automatic test_reset_mid_count();
        int due;
        ack_pulse();
        drive_sw(4'b1010, due);
        repeat (7) @(negedge clock);
        i_reset_n = 1'b0;
        q.delete();
        model_stable = '0;
        tog_model = '0;
        #1;
        total += 3;
        if (o_sw_stable !== '0) begin bad++; $display("FAIL midrst_stable got=%b exp=0000", o_sw_stable); end
        if (o_event_mask !== '0) begin bad++; $display("FAIL midrst_mask got=%b exp=0000", o_event_mask); end
        if (o_event_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", o_event_valid); end
        repeat (2) @(negedge clock);
        i_reset_n = 1'b1;
        drive_sw(4'b1010, due);
        wait_cyc(due + 1);
        total += 2;
        if (o_sw_stable !== 4'b1010) begin bad++; $display("FAIL postrst_stable got=%b exp=1010", o_sw_stable); end
        if (o_event_mask !== 4'b1010) begin bad++; $display("FAIL postrst_mask got=%b exp=1010", o_event_mask); end
    endtask

    task automatic test_toggle();
        int due;
        logic [NSW-1:0] exp_tog;
        ack_pulse();
        drive_sw(4'b1011, due);
        wait_cyc(due + 1);
`ifdef SW_DEBOUNCER_TOGGLE_EN
        exp_tog = tog_model;
`else
        exp_tog = '0;
`endif
        total++;
        if (o_sw_toggle !== exp_tog) begin bad++; $display("FAIL toggle_first got=%b exp=%b", o_sw_toggle, exp_tog); end
        drive_sw(4'b1010, due);
        wait_cyc(due + 1);
        drive_sw(4'b1011, due);
        wait_cyc(due + 1);
        drive_sw(4'b1010, due);
        wait_cyc(due + 1);
`ifdef SW_DEBOUNCER_TOGGLE_EN
        exp_tog = tog_model;
`else
        exp_tog = '0;
`endif
        total++;
        if (o_sw_toggle !== exp_tog) begin bad++; $display("FAIL toggle_second got=%b exp=%b", o_sw_toggle, exp_tog); end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_ack();
        test_bounce();
        test_ack_collision();
        test_reset_mid_count();
        test_toggle();
        repeat (LAT + 4) @(negedge clock);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
